// File: rtl/imm_packer.sv
// rtl/imm_packer.sv - packs a signed immediate into an RV32I instruction word
//
// Takes a base instruction word and a 32-bit signed immediate. It checks that
// the immediate is representable in the selected format, then writes its bits
// into the I/S/B/U/J immediate fields. Accepted words are presented with a
// sequential byte address for the instruction-memory preload path.
//
// Optional feature macro: IMM_PACKER_ROUNDTRIP_EN
//   When defined, the candidate word is decoded back to an immediate in CHECK
//   and any mismatch is rejected with err_code 2'b11.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   in_valid    request valid            in_ready   request accepted in IDLE
//   imm_type    000 I, 001 S, 010 B, 011 U, 100 J
//   imm_value   signed immediate         base_word  opcode/regs/funct source
//   out_valid   packed word valid        out_ready  consumer accepts word
//   out_instr   packed instruction       out_addr   byte address of out_instr
//   err_valid   one-cycle reject pulse   err_code   01 range, 10 type, 11 round-trip
//   err_count   saturating reject count

module imm_packer #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                ERR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        imm_type,
    input  logic [31:0]       imm_value,
    input  logic [31:0]       base_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [ERR_W-1:0]  err_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    localparam logic [2:0] T_I = 3'b000;
    localparam logic [2:0] T_S = 3'b001;
    localparam logic [2:0] T_B = 3'b010;
    localparam logic [2:0] T_U = 3'b011;
    localparam logic [2:0] T_J = 3'b100;

    state_t             state_q;
    state_t             state_d;

    logic [2:0]         type_q;
    logic [31:0]        imm_q;
    logic [31:0]        base_q;

    logic [31:0]        instr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               err_valid_q;
    logic [1:0]         err_code_q;
    logic [ERR_W-1:0]   err_count_q;

    logic               type_ok;
    logic               range_ok;
    logic               rt_ok;
    logic [31:0]        pack_word;
    logic [1:0]         fail_code;
    logic               check_pass;

    // Field scatter and range check on the captured request. A value fits an
    // N-bit signed field when all bits from N-1 upward are identical.
    always_comb begin
        type_ok   = 1'b1;
        range_ok  = 1'b0;
        pack_word = base_q;
        case (type_q)
            T_I: begin
                range_ok          = (&imm_q[31:11]) | ~(|imm_q[31:11]);
                pack_word[31:20]  = imm_q[11:0];
            end
            T_S: begin
                range_ok          = (&imm_q[31:11]) | ~(|imm_q[31:11]);
                pack_word[31:25]  = imm_q[11:5];
                pack_word[11:7]   = imm_q[4:0];
            end
            T_B: begin
                range_ok          = ~imm_q[0] & ((&imm_q[31:12]) | ~(|imm_q[31:12]));
                pack_word[31]     = imm_q[12];
                pack_word[30:25]  = imm_q[10:5];
                pack_word[11:8]   = imm_q[4:1];
                pack_word[7]      = imm_q[11];
            end
            T_U: begin
                range_ok          = ~(|imm_q[11:0]);
                pack_word[31:12]  = imm_q[31:12];
            end
            T_J: begin
                range_ok          = ~imm_q[0] & ((&imm_q[31:20]) | ~(|imm_q[31:20]));
                pack_word[31]     = imm_q[20];
                pack_word[30:21]  = imm_q[10:1];
                pack_word[20]     = imm_q[11];
                pack_word[19:12]  = imm_q[19:12];
            end
            default: type_ok = 1'b0;
        endcase
    end

`ifdef IMM_PACKER_ROUNDTRIP_EN
    logic [31:0] decoded;

    // Independent decode of the candidate word, as the datapath extender does.
    always_comb begin
        decoded = '0;
        case (type_q)
            T_I: decoded = {{20{pack_word[31]}}, pack_word[31:20]};
            T_S: decoded = {{20{pack_word[31]}}, pack_word[31:25], pack_word[11:7]};
            T_B: decoded = {{19{pack_word[31]}}, pack_word[31], pack_word[7],
                            pack_word[30:25], pack_word[11:8], 1'b0};
            T_U: decoded = {pack_word[31:12], 12'b0};
            T_J: decoded = {{11{pack_word[31]}}, pack_word[31], pack_word[19:12],
                            pack_word[20], pack_word[30:21], 1'b0};
            default: decoded = '0;
        endcase
        rt_ok = (decoded == imm_q);
    end
`else
    assign rt_ok = 1'b1;
`endif

    // Illegal type outranks range, which outranks round-trip.
    always_comb begin
        fail_code = 2'b00;
        if (!type_ok) begin
            fail_code = 2'b10;
        end else if (!range_ok) begin
            fail_code = 2'b01;
        end else if (!rt_ok) begin
            fail_code = 2'b11;
        end
    end

    assign check_pass = (fail_code == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = check_pass ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            type_q      <= '0;
            imm_q       <= '0;
            base_q      <= '0;
            instr_q     <= '0;
            addr_q      <= START_ADDR;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
            err_count_q <= '0;
        end else begin
            err_valid_q <= 1'b0;
            if (state_q == S_IDLE && in_valid) begin
                type_q <= imm_type;
                imm_q  <= imm_value;
                base_q <= base_word;
            end
            if (state_q == S_CHECK) begin
                if (check_pass) begin
                    instr_q <= pack_word;
                end else begin
                    err_valid_q <= 1'b1;
                    err_code_q  <= fail_code;
                    if (err_count_q != '1) begin
                        err_count_q <= err_count_q + ERR_W'(1);
                    end
                end
            end
            if (state_q == S_OUT && out_ready) begin
                addr_q <= addr_q + ADDR_W'(4);
            end
        end
    end

    assign out_instr = instr_q;
    assign out_addr  = addr_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_packer.sv
// tb/tb_imm_packer.sv - self-checking bench for imm_packer

module tb_imm_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  imm_type = '0;
    logic [31:0] imm_value = '0;
    logic [31:0] base_word = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, err_valid;
    logic [31:0] out_instr, out_addr;
    logic [1:0]  err_code;
    logic [7:0]  err_count;

    logic        in_ready2, out_valid2, err_valid2;
    logic [31:0] out_instr2;
    logic [3:0]  out_addr2;
    logic [1:0]  err_code2;
    logic [1:0]  err_count2;

    int passed = 0;
    int total  = 0;

    logic [31:0] m_addr;
    logic [7:0]  m_err;
    logic [3:0]  m_addr2;
    logic [1:0]  m_err2;

    always #5 clk = ~clk;

    imm_packer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .imm_type(imm_type), .imm_value(imm_value), .base_word(base_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err_valid(err_valid), .err_code(err_code),
        .err_count(err_count)
    );

    imm_packer #(.ADDR_W(4), .START_ADDR(4'hC), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .imm_type(imm_type), .imm_value(imm_value), .base_word(base_word),
        .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
        .out_addr(out_addr2), .err_valid(err_valid2), .err_code(err_code2),
        .err_count(err_count2)
    );

    // Reference: range limits as signed arithmetic, packing as mask-and-shift.
    function automatic void model(input logic [2:0] t, input logic [31:0] imm,
                                  input logic [31:0] base, output bit ok,
                                  output logic [1:0] code, output logic [31:0] word);
        int s;
        s = $signed(imm);
        ok = 0; code = 2'b01; word = 32'h0;
        case (t)
            3'd0: begin
                ok = (s >= -2048 && s <= 2047);
                word = (base & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
            end
            3'd1: begin
                ok = (s >= -2048 && s <= 2047);
                word = (base & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            end
            3'd2: begin
                ok = (s % 2 == 0) && s >= -4096 && s <= 4095;
                word = (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                     | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
            end
            3'd3: begin
                ok = ((imm & 32'hFFF) == 0);
                word = (base & 32'hFFF) | (imm & 32'hFFFF_F000);
            end
            3'd4: begin
                ok = (s % 2 == 0) && s >= -1048576 && s <= 1048575;
                word = (base & 32'hFFF) | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                     | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
            end
            default: begin
                ok = 0;
                code = 2'b10;
            end
        endcase
        if (ok) code = 2'b00;
    endfunction

    task automatic model_commit(input bit ok);
        if (ok) begin
            m_addr  = m_addr + 4;
            m_addr2 = m_addr2 + 4'd4;
        end else begin
            if (m_err != 8'hFF) m_err = m_err + 1;
            if (m_err2 != 2'd3) m_err2 = m_err2 + 1;
        end
    endtask

    task automatic apply_reset();
        rst = 1; in_valid = 0; out_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        m_addr = 0; m_err = 0; m_addr2 = 4'hC; m_err2 = 0;
    endtask

    // Drives one request and collects what the DUT did with it.
    task automatic do_req(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base,
                          input int stall, output bit got_out, output bit got_err,
                          output logic [31:0] instr, output logic [31:0] addr,
                          output logic [1:0] code, output int lat,
                          output bit hold_ok, output bit pulse_ok);
        int n;
        got_out = 0; got_err = 0; instr = 0; addr = 0; code = 0; lat = 0;
        hold_ok = 1; pulse_ok = 1;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        in_valid = 1; imm_type = t; imm_value = imm; base_word = base;
        @(posedge clk); #1;
        in_valid = 0; imm_type = 3'($urandom); imm_value = $urandom; base_word = $urandom;
        lat = 1;
        if (in_ready) hold_ok = 0;
        while (!out_valid && !err_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (err_valid) begin
            got_err = 1; code = err_code;
            if (out_valid) got_out = 1;
            @(posedge clk); #1;
            if (err_valid) pulse_ok = 0;
        end else if (out_valid) begin
            got_out = 1; instr = out_instr; addr = out_addr;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                if (!out_valid || out_instr !== instr || out_addr !== addr || in_ready) hold_ok = 0;
            end
            out_ready = 1;
            @(posedge clk); #1;
            out_ready = 0;
            if (out_valid) hold_ok = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready actual=%b expected=0", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid actual=%b expected=0", out_valid); else passed++;
        total++; if (out_instr !== 32'h0) $display("FAIL rst_out_instr actual=%h expected=0", out_instr); else passed++;
        total++; if (out_addr !== 32'h0) $display("FAIL rst_out_addr actual=%h expected=0", out_addr); else passed++;
        total++; if (err_valid !== 1'b0 || err_code !== 2'b00) $display("FAIL rst_err actual=%b/%b expected=0/00", err_valid, err_code); else passed++;
        total++; if (err_count !== 8'h0) $display("FAIL rst_err_count actual=%0d expected=0", err_count); else passed++;
        total++; if (out_addr2 !== 4'hC) $display("FAIL rst_out_addr2 actual=%h expected=c", out_addr2); else passed++;
        rst = 0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready actual=%b expected=1", in_ready); else passed++;
        m_addr = 0; m_err = 0; m_addr2 = 4'hC; m_err2 = 0;
    endtask

    task automatic test_type_i();
        bit go, ge, ho, po; logic [31:0] ins, ad; logic [1:0] cd; int lat;
        apply_reset();
        do_req(3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 0, go, ge, ins, ad, cd, lat, ho, po);
        model_commit(1);
        total++; if (go !== 1 || ge !== 0) $display("FAIL i_outcome actual=out%0d err%0d expected=out1 err0", go, ge); else passed++;
        total++; if (ins !== 32'hFFF0_0013) $display("FAIL i_instr actual=%h expected=fff00013", ins); else passed++;
        total++; if (ad !== 32'h0) $display("FAIL i_addr actual=%h expected=0", ad); else passed++;
        total++; if (lat != 2) $display("FAIL i_latency actual=%0d expected=2", lat); else passed++;
        total++; if (out_addr !== m_addr) $display("FAIL i_addr_next actual=%h expected=%h", out_addr, m_addr); else passed++;
    endtask

    task automatic test_back_to_back();
        bit go, ge, ho, po; logic [31:0] ins, ad; logic [1:0] cd; int lat;
        time t0;
        apply_reset();
        t0 = $time;
        do_req(3'd1, 32'h0000_0024, 32'h0000_2023, 0, go, ge, ins, ad, cd, lat, ho, po);
        model_commit(1);
        total++; if (ins !== 32'h0200_2223 || ad !== 32'h0) $display("FAIL s_word actual=%h@%h expected=02002223@0", ins, ad); else passed++;
        do_req(3'd3, 32'h1234_5000, 32'h0000_0037, 0, go, ge, ins, ad, cd, lat, ho, po);
        model_commit(1);
        total++; if (ins !== 32'h1234_5037 || ad !== 32'h4) $display("FAIL u_word actual=%h@%h expected=12345037@4", ins, ad); else passed++;
        total++; if ($time - t0 != 60) $display("FAIL b2b_cycles actual=%0t expected=60", $time - t0); else passed++;
    endtask

    task automatic test_b_range();
        bit go, ge, ho, po, ok; logic [31:0] ins, ad, w; logic [1:0] cd, mc; int lat;
        apply_reset();
        do_req(3'd2, 32'hFFFF_FFFC, 32'h0000_0063, 0, go, ge, ins, ad, cd, lat, ho, po);
        model_commit(1);
        total++; if (ins !== 32'hFE00_0EE3 || ad !== 32'h0) $display("FAIL b_word actual=%h@%h expected=fe000ee3@0", ins, ad); else passed++;
        do_req(3'd2, 32'h0000_0003, 32'h0000_0063, 0, go, ge, ins, ad, cd, lat, ho, po);
        model_commit(0);
        total++; if (ge !== 1 || go !== 0) $display("FAIL b_reject actual=out%0d err%0d expected=out0 err1", go, ge); else passed++;
        total++; if (cd !== 2'b01) $display("FAIL b_err_code actual=%b expected=01", cd); else passed++;
        total++; if (po !== 1 || lat != 2) $display("FAIL b_err_pulse actual=once%0d lat%0d expected=once1 lat2", po, lat); else passed++;
        total++; if (err_count !== 8'd1) $display("FAIL b_err_count actual=%0d expected=1", err_count); else passed++;
        model(3'd2, 32'h0000_0008, 32'h0000_0063, ok, mc, w);
        do_req(3'd2, 32'h0000_0008, 32'h0000_0063, 0, go, ge, ins, ad, cd, lat, ho, po);
        model_commit(ok);
        total++; if (ins !== w || ad !== 32'h4) $display("FAIL b_after_err actual=%h@%h expected=%h@4", ins, ad, w); else passed++;
    endtask

    task automatic test_j_backpressure();
        bit go, ge, ho, po; logic [31:0] ins, ad, a0; logic [1:0] cd; int lat;
        a0 = m_addr;
        do_req(3'd4, 32'h0000_0800, 32'h0000_006F, 3, go, ge, ins, ad, cd, lat, ho, po);
        model_commit(1);
        total++; if (ins !== 32'h0010_006F) $display("FAIL j_instr actual=%h expected=0010006f", ins); else passed++;
        total++; if (ho !== 1) $display("FAIL j_hold actual=%0d expected=1", ho); else passed++;
        total++; if (ad !== a0) $display("FAIL j_addr_held actual=%h expected=%h", ad, a0); else passed++;
        total++; if (out_addr !== m_addr) $display("FAIL j_addr_next actual=%h expected=%h", out_addr, m_addr); else passed++;
    endtask

    task automatic test_illegal_type();
        bit go, ge, ho, po; logic [31:0] ins, ad; logic [1:0] cd; int lat;
        out_ready = 1;
        do_req(3'd5, 32'h7FFF_FFFF, 32'h0000_0013, 0, go, ge, ins, ad, cd, lat, ho, po);
        model_commit(0);
        total++; if (ge !== 1 || cd !== 2'b10) $display("FAIL type_err actual=err%0d code%b expected=err1 code10", ge, cd); else passed++;
        total++; if (go !== 0) $display("FAIL type_no_out actual=%0d expected=0", go); else passed++;
        @(posedge clk); #1;
        total++; if (out_addr !== m_addr || out_valid !== 0) $display("FAIL type_addr actual=%h v%b expected=%h v0", out_addr, out_valid, m_addr); else passed++;
        total++; if (err_count !== m_err) $display("FAIL type_err_count actual=%0d expected=%0d", err_count, m_err); else passed++;
        out_ready = 0;
    endtask

    task automatic test_reset_in_check();
        int n;
        apply_reset();
        do_req_dummy_advance: begin
            n = 0;
            while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        end
        in_valid = 1; imm_type = 3'd0; imm_value = 32'd5; base_word = 32'h13;
        @(posedge clk); #1;
        in_valid = 0; rst = 1;
        @(posedge clk); #1;
        total++; if (out_valid !== 0 || in_ready !== 0) $display("FAIL rstchk_ctrl actual=v%b r%b expected=v0 r0", out_valid, in_ready); else passed++;
        total++; if (out_instr !== 0 || out_addr !== 0) $display("FAIL rstchk_data actual=%h@%h expected=0@0", out_instr, out_addr); else passed++;
        total++; if (err_valid !== 0 || err_count !== 0 || out_addr2 !== 4'hC) $display("FAIL rstchk_err actual=%b/%0d/%h expected=0/0/c", err_valid, err_count, out_addr2); else passed++;
        rst = 0;
        m_addr = 0; m_err = 0; m_addr2 = 4'hC; m_err2 = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (out_valid !== 0 || in_ready !== 1) $display("FAIL rstchk_after actual=v%b r%b expected=v0 r1", out_valid, in_ready); else passed++;
    endtask

    task automatic test_counter_limits();
        bit go, ge, ho, po; logic [31:0] ins, ad; logic [1:0] cd; int lat;
        apply_reset();
        do_req(3'd0, 32'h0000_0010, 32'h0000_0013, 0, go, ge, ins, ad, cd, lat, ho, po);
        model_commit(1);
        total++; if (out_addr2 !== 4'h0) $display("FAIL addr_wrap actual=%h expected=0", out_addr2); else passed++;
        for (int i = 0; i < 5; i++) begin
            do_req(3'd7, 32'h0, 32'h0, 0, go, ge, ins, ad, cd, lat, ho, po);
            model_commit(0);
        end
        total++; if (err_count2 !== 2'd3) $display("FAIL err_sat actual=%0d expected=3", err_count2); else passed++;
        total++; if (err_count !== 8'd5) $display("FAIL err_count5 actual=%0d expected=5", err_count); else passed++;
    endtask

    task automatic test_random();
        bit go, ge, ho, po, ok; logic [31:0] ins, ad, w, imm, base, a0; logic [1:0] cd, mc; int lat;
        logic [2:0] t;
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            t = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                2: imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'h1;
                default: imm = $urandom & 32'hFFFF_F000;
            endcase
            base = $urandom;
            model(t, imm, base, ok, mc, w);
            a0 = m_addr;
            do_req(t, imm, base, $urandom_range(0, 2), go, ge, ins, ad, cd, lat, ho, po);
            model_commit(ok);
            total++; if (go !== ok || ge !== !ok) $display("FAIL rnd_outcome t=%0d imm=%h actual=out%0d err%0d expected_ok=%0d", t, imm, go, ge, ok); else passed++;
            if (ok) begin
                total++; if (ins !== w || ad !== a0) $display("FAIL rnd_word t=%0d imm=%h actual=%h@%h expected=%h@%h", t, imm, ins, ad, w, a0); else passed++;
                total++; if (ho !== 1) $display("FAIL rnd_hold t=%0d actual=%0d expected=1", t, ho); else passed++;
            end else begin
                total++; if (cd !== mc || po !== 1) $display("FAIL rnd_code t=%0d imm=%h actual=%b expected=%b", t, imm, cd, mc); else passed++;
            end
            total++; if (lat != 2) $display("FAIL rnd_latency actual=%0d expected=2", lat); else passed++;
            total++; if (out_addr !== m_addr || err_count !== m_err) $display("FAIL rnd_counters actual=%h/%0d expected=%h/%0d", out_addr, err_count, m_addr, m_err); else passed++;
            total++; if (out_addr2 !== m_addr2 || err_count2 !== m_err2) $display("FAIL rnd_counters2 actual=%h/%0d expected=%h/%0d", out_addr2, err_count2, m_addr2, m_err2); else passed++;
        end
    endtask

    initial begin
        m_addr = 0; m_err = 0; m_addr2 = 4'hC; m_err2 = 0;
        test_reset();
        test_type_i();
        test_back_to_back();
        test_b_range();
        test_j_backpressure();
        test_illegal_type();
        test_reset_in_check();
        test_counter_limits();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
